// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between instruction fetch (read-only) and the
// data stage (load/store). Only one access is outstanding at a time. The
// granted request is held on the memory side until mem_ack_i arrives. The data
// port normally wins a tie. A starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants made while a fetch was waiting.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i  fetch request and address
//   if_data_o/if_ack_o  fetched word and its one-cycle completion pulse
//   dm_req_i/dm_we_i    data request and store flag
//   dm_addr_i/dm_wdata_i data address and store data
//   dm_rdata_o/dm_ack_o load word and its one-cycle completion pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  request towards memory
//   mem_rdata_i/mem_ack_i                      memory response
//   pc_stall_o/pipe_stall_o  combinational pipeline stalls
//   busy_o              high while an access is outstanding
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              pc_stall_o,
  output logic              pipe_stall_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  logic [3:0]        r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              r_busy;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_grant_dm;
  logic w_grant_if;

  // A request that is still high during its own ack cycle is the one just
  // served, not a new one, so it is not eligible.
  assign w_if_elig  = if_req_i & ~r_if_ack;
  assign w_dm_elig  = dm_req_i & ~r_dm_ack;
  // Data wins a tie unless the fetch side has waited out STARVE_MAX data grants.
  assign w_grant_dm = w_dm_elig & ~(w_if_elig & (r_starve_cnt == STARVE_LIM));
  assign w_grant_if = w_if_elig & ~w_grant_dm;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 4'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_data    <= '0;
      r_dm_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // mem_ack_i is ignored here; no access is outstanding.
          if (w_grant_dm) begin
            r_state     <= ST_DM_BUSY;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            // Counts data grants made while a fetch is pending; saturates.
            if (if_req_i) begin
              if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
              end
            end else begin
              r_starve_cnt <= 4'd0;
            end
          end else if (w_grant_if) begin
            r_state      <= ST_IF_BUSY;
            r_busy       <= 1'b1;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr_i;
            r_mem_wdata  <= '0;
            r_starve_cnt <= 4'd0;
          end
        end
        ST_IF_BUSY: begin
          if (mem_ack_i) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_if_ack  <= 1'b1;
            r_if_data <= mem_rdata_i;
          end
        end
        ST_DM_BUSY: begin
          if (mem_ack_i) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_dm_ack   <= 1'b1;
            // Loaded on stores too; the value is meaningless in that case.
            r_dm_rdata <= mem_rdata_i;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign if_data_o    = r_if_data;
  assign if_ack_o     = r_if_ack;
  assign dm_rdata_o   = r_dm_rdata;
  assign dm_ack_o     = r_dm_ack;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign busy_o       = r_busy;
  assign pipe_stall_o = dm_req_i & ~r_dm_ack;
  assign pc_stall_o   = (if_req_i & ~r_if_ack) | pipe_stall_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run that is
// checked cycle by cycle against a behavioural model with a shadow memory.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk_i, rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i, if_data_o;
  logic        if_ack_o;
  logic        dm_req_i, dm_we_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        pc_stall_o, pipe_stall_o, busy_o;

  // Memory responder (automatic) and directly forced acks share the ack wire.
  logic        tb_auto_ack, tb_force_ack;
  logic [31:0] tb_auto_data, tb_force_data;
  logic        mem_auto;
  int          mem_lat;     // <0 selects a random latency of 0..3
  logic        pend;
  int          wcnt;
  logic [31:0] tb_mem [0:255];

  int checks = 0;
  int errors = 0;

  assign mem_ack_i   = tb_auto_ack | tb_force_ack;
  assign mem_rdata_i = tb_force_ack ? tb_force_data : tb_auto_data;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_o), .pipe_stall_o(pipe_stall_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory model: after `latency` idle busy cycles, acks for one cycle.
  always @(posedge clk_i) begin
    #1;
    if (tb_auto_ack) begin
      tb_auto_ack = 1'b0;
    end else if (mem_auto && mem_req_o && rst_i) begin
      if (!pend) begin
        pend = 1'b1;
        wcnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (wcnt == 0) begin
        pend = 1'b0;
        tb_auto_ack = 1'b1;
        if (mem_we_o) begin
          tb_mem[mem_addr_o[9:2]] = mem_wdata_o;
          tb_auto_data = $urandom;
        end else begin
          tb_auto_data = tb_mem[mem_addr_o[9:2]];
        end
      end else begin
        wcnt--;
      end
    end else begin
      pend = 1'b0;
    end
  end

  task automatic apply_reset;
    rst_i = 1'b0;
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, busy_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, busy_o}); end
    checks++; if ({mem_addr_o, mem_wdata_o} !== 64'd0) begin
      errors++; $display("FAIL reset_mem_bus: got %h_%h expected 0", mem_addr_o, mem_wdata_o); end
    checks++; if ({if_data_o, dm_rdata_o} !== 64'd0) begin
      errors++; $display("FAIL reset_data: got %h_%h expected 0", if_data_o, dm_rdata_o); end
    checks++; if ({pc_stall_o, pipe_stall_o} !== 2'b00) begin
      errors++; $display("FAIL reset_stall: got %b expected 00", {pc_stall_o, pipe_stall_o}); end
    @(posedge clk_i); #1 rst_i = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_single_fetch;
    tb_mem[4] = 32'h8C01_0004;
    mem_lat = 0; mem_auto = 1'b1;
    @(posedge clk_i); #1 if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    @(negedge clk_i);
    checks++; if (pc_stall_o !== 1'b1) begin errors++; $display("FAIL fetch_pc_stall: got %b expected 1", pc_stall_o); end
    @(negedge clk_i);  // grant edge has passed
    checks++; if ({mem_req_o, mem_we_o, busy_o, if_ack_o} !== 4'b1010) begin
      errors++; $display("FAIL fetch_grant: got %b expected 1010", {mem_req_o, mem_we_o, busy_o, if_ack_o}); end
    checks++; if (mem_addr_o !== 32'h10) begin errors++; $display("FAIL fetch_addr: got %h expected 00000010", mem_addr_o); end
    @(posedge clk_i); #1 if_req_i = 1'b0;
    @(negedge clk_i);  // ack edge has passed
    checks++; if ({if_ack_o, mem_req_o} !== 2'b10) begin
      errors++; $display("FAIL fetch_ack: got %b expected 10", {if_ack_o, mem_req_o}); end
    checks++; if (if_data_o !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_data: got %h expected 8c010004", if_data_o); end
    @(negedge clk_i);
    checks++; if ({if_ack_o, busy_o} !== 2'b00) begin errors++; $display("FAIL fetch_pulse: got %b expected 00", {if_ack_o, busy_o}); end
    checks++; if (if_data_o !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_hold: got %h expected 8c010004", if_data_o); end
    $display("txn IF addr=00000010 data=%h", if_data_o);
  endtask

  task automatic test_store_load;
    logic seen;
    mem_lat = 2; mem_auto = 1'b1;
    for (int op = 0; op < 2; op++) begin
      @(posedge clk_i); #1
      dm_req_i = 1'b1; dm_we_i = (op == 0); dm_addr_i = 32'h40; dm_wdata_i = (op == 0) ? 32'hDEAD_BEEF : 32'h0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk_i);
        if (dm_ack_o) begin
          seen = 1'b1;
        end else begin
          checks++; if (pipe_stall_o !== 1'b1) begin errors++; $display("FAIL sl_pipe_stall op%0d: got %b expected 1", op, pipe_stall_o); end
          if (mem_req_o) begin
            checks++; if (mem_we_o !== (op == 0)) begin errors++; $display("FAIL sl_we op%0d: got %b expected %0d", op, mem_we_o, op == 0); end
          end
        end
      end
      checks++; if (!seen) begin errors++; $display("FAIL sl_timeout op%0d: got no dm_ack expected dm_ack", op); end
      checks++; if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL sl_stall_ack op%0d: got %b expected 0", op, pipe_stall_o); end
      if (op == 1) begin
        checks++; if (dm_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sl_load_data: got %h expected deadbeef", dm_rdata_o); end
      end
      dm_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL sl_we_after op%0d: got %b expected 0", op, mem_we_o); end
      $display("txn DM %s addr=00000040 data=%h", (op == 0) ? "store" : "load", (op == 0) ? 32'hDEAD_BEEF : dm_rdata_o);
    end
  endtask

  task automatic test_spurious_idle;
    mem_auto = 1'b0;
    @(posedge clk_i); #1 tb_force_ack = 1'b1; tb_force_data = 32'h1234_5678;
    @(posedge clk_i); #1 tb_force_ack = 1'b0;
    @(negedge clk_i);
    checks++; if ({if_ack_o, dm_ack_o, busy_o, mem_req_o} !== 4'b0) begin
      errors++; $display("FAIL spur_ctrl: got %b expected 0000", {if_ack_o, dm_ack_o, busy_o, mem_req_o}); end
    checks++; if (if_data_o !== 32'h8C01_0004) begin errors++; $display("FAIL spur_if_data: got %h expected 8c010004", if_data_o); end
    checks++; if (dm_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL spur_dm_data: got %h expected deadbeef", dm_rdata_o); end
    $display("txn spurious mem_ack in IDLE");
  endtask

  task automatic test_stale_guard;
    logic seen;
    mem_lat = 0; mem_auto = 1'b1; tb_mem[8] = 32'hCAFE_0020;
    @(posedge clk_i); #1 if_req_i = 1'b1; if_addr_i = 32'h20;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk_i);
      if (if_ack_o) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL stale_timeout: got no if_ack expected if_ack"); end
    @(posedge clk_i); #1 if_req_i = 1'b0;   // held through the ack cycle
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      checks++; if ({mem_req_o, busy_o} !== 2'b00) begin
        errors++; $display("FAIL stale_regrant c%0d: got %b expected 00", n, {mem_req_o, busy_o}); end
    end
    $display("txn IF addr=00000020 data=%h (stale request held)", if_data_o);
  endtask

  task automatic test_starvation;
    logic seen, got_if, exp_if;
    apply_reset();
    mem_lat = 0; mem_auto = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1
      if_req_i = 1'b1; if_addr_i = 32'h100;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk_i);
        if (mem_req_o) seen = 1'b1;
      end
      exp_if = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      got_if = (mem_addr_o == 32'h100);
      checks++; if (!seen || got_if !== exp_if) begin
        errors++; $display("FAIL starve_grant k%0d: got %s expected %s", k, !seen ? "none" : (got_if ? "IF" : "DM"), exp_if ? "IF" : "DM"); end
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk_i);
        if (if_ack_o || dm_ack_o) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL starve_ack_timeout k%0d: got no ack expected ack", k); end
      if_req_i = 1'b0; dm_req_i = 1'b0;
      $display("txn contention grant %0d -> %s", k, got_if ? "IF" : "DM");
    end
  endtask

  task automatic test_reset_mid;
    mem_auto = 1'b0;
    @(posedge clk_i); #1 dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h5555_AAAA;
    @(negedge clk_i); @(negedge clk_i);
    checks++; if ({mem_req_o, busy_o} !== 2'b11) begin errors++; $display("FAIL rmid_busy: got %b expected 11", {mem_req_o, busy_o}); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if ({mem_req_o, mem_we_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL rmid_async: got %b expected 000", {mem_req_o, mem_we_o, busy_o}); end
    checks++; if ({mem_addr_o, mem_wdata_o} !== 64'd0) begin errors++; $display("FAIL rmid_bus: got %h_%h expected 0", mem_addr_o, mem_wdata_o); end
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 tb_force_ack = 1'b1; tb_force_data = 32'h7777_7777;
    @(posedge clk_i); #1 tb_force_ack = 1'b0;
    @(negedge clk_i);
    checks++; if ({if_ack_o, dm_ack_o, busy_o, mem_req_o} !== 4'b0) begin
      errors++; $display("FAIL rmid_spur: got %b expected 0000", {if_ack_o, dm_ack_o, busy_o, mem_req_o}); end
    checks++; if ({if_data_o, dm_rdata_o} !== 64'd0) begin errors++; $display("FAIL rmid_data: got %h_%h expected 0", if_data_o, dm_rdata_o); end
    $display("txn reset during DM access");
  endtask

  // Randomized traffic against a behavioural model: who owns the memory,
  // the grant policy with starvation count, and a shadow copy of memory.
  task automatic test_random;
    int          owner;  // 0 none, 1 fetch, 2 data
    int          cnt;
    logic        e_req, e_we, e_if_ack, e_dm_ack, dm_known, ife, dme, n_if_ack, n_dm_ack;
    logic [31:0] e_addr, e_wdata, e_if_data, e_dm_rdata;
    logic [31:0] sm [0:255];
    apply_reset();
    for (int i = 0; i < 256; i++) sm[i] = tb_mem[i];
    owner = 0; cnt = 0; e_req = 0; e_we = 0; e_if_ack = 0; e_dm_ack = 0; dm_known = 1;
    e_addr = 0; e_wdata = 0; e_if_data = 0; e_dm_rdata = 0;
    mem_lat = -1; mem_auto = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk_i); #1;
      if (if_req_i) begin
        if (if_ack_o ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0)) if_req_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1; if_addr_i = 32'($urandom_range(0, 15)) << 2;
      end
      if (dm_req_i) begin
        if (dm_ack_o ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0)) dm_req_i = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        dm_req_i = 1'b1; dm_we_i = $urandom_range(0, 1) == 1;
        dm_addr_i = 32'($urandom_range(0, 15)) << 2; dm_wdata_i = $urandom;
      end
      @(negedge clk_i);
      checks++; if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, busy_o} !== {e_req, e_we, e_if_ack, e_dm_ack, owner != 0}) begin
        errors++; $display("FAIL rnd_ctrl c%0d: got %b expected %b", cyc, {mem_req_o, mem_we_o, if_ack_o, dm_ack_o, busy_o},
                           {e_req, e_we, e_if_ack, e_dm_ack, owner != 0}); end
      if (e_req) begin
        checks++; if ({mem_addr_o, mem_wdata_o} !== {e_addr, e_wdata}) begin
          errors++; $display("FAIL rnd_bus c%0d: got %h_%h expected %h_%h", cyc, mem_addr_o, mem_wdata_o, e_addr, e_wdata); end
      end
      checks++; if (if_data_o !== e_if_data) begin errors++; $display("FAIL rnd_if_data c%0d: got %h expected %h", cyc, if_data_o, e_if_data); end
      if (dm_known) begin
        checks++; if (dm_rdata_o !== e_dm_rdata) begin errors++; $display("FAIL rnd_dm_data c%0d: got %h expected %h", cyc, dm_rdata_o, e_dm_rdata); end
      end
      checks++; if ({pc_stall_o, pipe_stall_o} !== {(if_req_i & ~e_if_ack) | (dm_req_i & ~e_dm_ack), dm_req_i & ~e_dm_ack}) begin
        errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", cyc, {pc_stall_o, pipe_stall_o},
                           {(if_req_i & ~e_if_ack) | (dm_req_i & ~e_dm_ack), dm_req_i & ~e_dm_ack}); end
      // Predict the effect of the coming edge from the inputs now applied.
      n_if_ack = 1'b0; n_dm_ack = 1'b0;
      if (owner == 0) begin
        ife = if_req_i && !e_if_ack;
        dme = dm_req_i && !e_dm_ack;
        if (dme && !(ife && cnt == STARVE_MAX)) begin
          owner = 2; e_req = 1; e_we = dm_we_i; e_addr = dm_addr_i; e_wdata = dm_wdata_i;
          cnt = if_req_i ? ((cnt < STARVE_MAX) ? cnt + 1 : cnt) : 0;
        end else if (ife) begin
          owner = 1; e_req = 1; e_we = 0; e_addr = if_addr_i; e_wdata = 0; cnt = 0;
        end
      end else if (mem_ack_i) begin
        if (owner == 1) begin
          n_if_ack = 1'b1; e_if_data = sm[e_addr[9:2]];
          $display("txn IF addr=%h data=%h", e_addr, e_if_data);
        end else begin
          n_dm_ack = 1'b1;
          if (e_we) begin
            sm[e_addr[9:2]] = e_wdata; dm_known = 1'b0;
            $display("txn DM store addr=%h data=%h", e_addr, e_wdata);
          end else begin
            e_dm_rdata = sm[e_addr[9:2]]; dm_known = 1'b1;
            $display("txn DM load addr=%h data=%h", e_addr, e_dm_rdata);
          end
        end
        owner = 0; e_req = 0; e_we = 0;
      end
      e_if_ack = n_if_ack; e_dm_ack = n_dm_ack;
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    tb_auto_ack = 1'b0; tb_force_ack = 1'b0; tb_auto_data = '0; tb_force_data = '0;
    mem_auto = 1'b0; mem_lat = 0; pend = 1'b0; wcnt = 0;
    for (int i = 0; i < 256; i++) tb_mem[i] = $urandom;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_spurious_idle();
    test_stale_guard();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Grants one requester at a time and holds the granted request stable until the memory acknowledges it.
- Returns read data to the granted port and drives PC and pipeline stall signals.
- Sits between the PC/IF_ID front end, the EX_MEM/MEM_WB stages and the external memory model.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, max consecutive data grants made while a fetch waits before fetch is forced (range 1..15)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request, held high until if_ack_o is seen
if_addr_i  in  ADDR_W  fetch address, stable while if_req_i is high
if_data_o  out  DATA_W  fetched instruction, valid with if_ack_o, held until next fetch ack
if_ack_o  out  1  one-cycle fetch completion pulse
dm_req_i  in  1  data request, held high until dm_ack_o is seen
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_rdata_o  out  DATA_W  load data, valid with dm_ack_o, held until next data ack
dm_ack_o  out  1  one-cycle data completion pulse
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion, one cycle
pc_stall_o  out  1  stall PC and IF_ID
pipe_stall_o  out  1  stall all pipeline registers
busy_o  out  1  1 when state is not IDLE

Behaviour:
Reset:
- While rst_i = 0: state = IDLE, starvation counter = 0.
- All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o, if_ack_o, dm_ack_o, busy_o.
- Reset mid-transaction abandons the access; mem_req_o drops asynchronously. The memory model tolerates a dropped request.

States are IDLE, IF_BUSY and DM_BUSY.

IDLE:
- A port is eligible when its req is 1 and its own ack_o is 0 in the current cycle. This stops a request still high during its ack cycle from being granted again.
- Neither port eligible: stay in IDLE.
- Only one port eligible: grant it.
- Both eligible: grant DM, unless counter == STARVE_MAX, in which case grant IF.
- At the grant edge:
  - Register mem_req_o = 1.
  - Register mem_addr_o from the granted port's address.
  - DM grant: mem_we_o = dm_we_i, mem_wdata_o = dm_wdata_i. IF grant: mem_we_o = 0, mem_wdata_o = 0.
  - Next state is IF_BUSY or DM_BUSY.

IF_BUSY / DM_BUSY:
- mem_* outputs are held stable.
- On an edge with mem_ack_i = 1:
  - mem_req_o goes to 0.
  - The granted port's ack_o is set for exactly one cycle.
  - Granted port's data_o = mem_rdata_i. On a store, dm_rdata_o is still loaded from mem_rdata_i; its value is don't-care.
  - Next state is IDLE.
- No return to IDLE without mem_ack_i; there is no timeout.
- The transaction completes even if the requester drops req early; ack still pulses.

mem_ack_i in IDLE is ignored. Minimum latency is 2 edges from req to ack_o (grant edge, then ack edge if memory acks in the first mem_req_o cycle). Throughput is at most one access per 2 cycles.

Starvation counter (4-bit):
- On a DM grant with if_req_i = 1: counter increments, saturating at STARVE_MAX.
- On a DM grant with if_req_i = 0: counter clears to 0.
- On an IF grant: counter clears to 0.

Stall outputs (combinational):
- pc_stall_o = (if_req_i & ~if_ack_o) | pipe_stall_o
- pipe_stall_o = dm_req_i & ~dm_ack_o
- busy_o = (state != IDLE), registered.

Simultaneous events:
- An ack edge and a new request in the same cycle: the new request is granted no earlier than the following IDLE edge.
- if_ack_o and dm_ack_o are never high in the same cycle.

Test Plan:
- Reset then single fetch: if_addr_i = 0x0000_0010, memory acks in the 1st busy cycle with 0x8C01_0004 -> mem_req_o rises 1 edge after req; if_ack_o pulses 1 cycle at edge 2; if_data_o = 0x8C01_0004 and holds after the pulse.
- Store then load to 0x40: store 0xDEAD_BEEF, then load from 0x40, memory latency 3 cycles -> mem_we_o = 1 only during the store; dm_rdata_o = 0xDEAD_BEEF; pipe_stall_o = 1 until each dm_ack_o.
- Contention: if_req_i and dm_req_i both held continuously, STARVE_MAX = 4 -> grant order DM, DM, DM, DM, IF, DM…; never 5 DM grants in a row while IF waits.
- Stale-request guard: requester keeps req high during its ack cycle and drops it 1 cycle later -> no second mem_req_o for that address.
- Reset mid-access: rst_i low during DM_BUSY, then a spurious mem_ack_i after release -> all outputs are 0; state stays IDLE; no ack pulse.
- Spurious mem_ack_i in IDLE with no requests -> no ack_o; busy_o stays 0; data outputs unchanged.
